// File: rtl/i2c_slave_wr.sv
// i2c_slave_wr: I2C/SCCB write-only responder for 4-byte register write frames
// (device address + W, register address high, register address low, data).
// The bus is oversampled on clock_sys. Each completed write appears as a
// one-cycle wr_valid strobe with a 16-bit address and 8-bit data.
module i2c_slave_wr #(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic        clock_sys,
    input  logic        camera_rst,
    input  logic        i2c_sclk,
    input  logic        i2c_sdat_in,
    output logic        i2c_sdat_oe,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        err,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, DATA, ACK_D, IGNORE
    } state_t;

    state_t      state_q, state_n;
    logic        scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
    logic        scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;
    logic [2:0]  bit_cnt_q, bit_cnt_n;
    logic [7:0]  shift_q, shift_n, byte_in;
    logic        ack_on_q, ack_on_n;     // 1 while this block is pulling SDA for an ACK
    logic        ack_slot_q, ack_slot_n; // IGNORE: next SCL rise is an ACK clock, not data
    logic        ign_err_q, ign_err_n;   // IGNORE entered after a completed write
    logic [7:0]  addr_hi_q, addr_hi_n, addr_lo_q, addr_lo_n, data_sh_q, data_sh_n;
    logic        oe_n, wr_valid_n, err_n;
    logic [15:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        incomplete;

    // Two-flop synchronizers, history flops and registered bus-event flags.
    // SDA is captured alongside the flags so a sampled bit lines up with its rise.
    always_ff @(posedge clock_sys) begin
        if (camera_rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
            scl_rise_q <= 1'b0; scl_fall_q <= 1'b0;
            start_q    <= 1'b0; stop_q     <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            scl_s1 <= i2c_sclk;    scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= i2c_sdat_in; sda_s2 <= sda_s1; sda_h <= sda_s2;
            scl_rise_q <= scl_s2 & ~scl_h;
            scl_fall_q <= ~scl_s2 & scl_h;
            start_q    <= scl_s2 & scl_h & sda_h & ~sda_s2;
            stop_q     <= scl_s2 & scl_h & ~sda_h & sda_s2;
            sda_q      <= sda_s2;
        end
    end

    assign byte_in    = {shift_q[6:0], sda_q};
    assign incomplete = (state_q == AH) || (state_q == ACK_AH) || (state_q == AL) ||
                        (state_q == ACK_AL) || (state_q == DATA) || (state_q == ACK_D);

    // Next-state and output logic; START/STOP override bit handling.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        shift_n    = shift_q;
        ack_on_n   = ack_on_q;
        ack_slot_n = ack_slot_q;
        ign_err_n  = ign_err_q;
        addr_hi_n  = addr_hi_q;
        addr_lo_n  = addr_lo_q;
        data_sh_n  = data_sh_q;
        oe_n       = i2c_sdat_oe;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        err_n      = 1'b0;
        if (stop_q || start_q) begin
            state_n    = stop_q ? IDLE : DEV;
            bit_cnt_n  = 3'd0;
            oe_n       = 1'b0;
            ack_on_n   = 1'b0;
            ack_slot_n = 1'b0;
            ign_err_n  = 1'b0;
            err_n      = incomplete;
        end else begin
            case (state_q)
                DEV, AH, AL, DATA: begin
                    if (scl_rise_q) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                DEV: begin
                                    if (byte_in == {DEV_ADDR, 1'b0}) begin
                                        state_n = ACK_DEV;
                                    end else begin
                                        state_n    = IGNORE;
                                        ack_slot_n = 1'b1;
                                        ign_err_n  = 1'b0;
                                        err_n      = (byte_in == {DEV_ADDR, 1'b1});
                                    end
                                end
                                AH:      begin addr_hi_n = byte_in; state_n = ACK_AH; end
                                AL:      begin addr_lo_n = byte_in; state_n = ACK_AL; end
                                default: begin data_sh_n = byte_in; state_n = ACK_D;  end
                            endcase
                        end
                    end
                end
                ACK_DEV, ACK_AH, ACK_AL, ACK_D: begin
                    if (scl_fall_q) begin
                        if (!ack_on_q) begin
                            oe_n     = 1'b1;
                            ack_on_n = 1'b1;
                        end else begin
                            oe_n     = 1'b0;
                            ack_on_n = 1'b0;
                            case (state_q)
                                ACK_DEV: state_n = AH;
                                ACK_AH:  state_n = AL;
                                ACK_AL:  state_n = DATA;
                                default: begin
                                    state_n    = IGNORE;
                                    ign_err_n  = 1'b1;
                                    ack_slot_n = 1'b0;
                                    wr_valid_n = 1'b1;
                                    wr_addr_n  = {addr_hi_q, addr_lo_q};
                                    wr_data_n  = data_sh_q;
                                end
                            endcase
                        end
                    end
                end
                IGNORE: begin
                    if (scl_rise_q) begin
                        if (ack_slot_q) begin
                            ack_slot_n = 1'b0;
                        end else begin
                            bit_cnt_n = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                ack_slot_n = 1'b1;
                                err_n      = ign_err_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock_sys) begin
        if (camera_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ack_on_q    <= 1'b0;
            ack_slot_q  <= 1'b0;
            ign_err_q   <= 1'b0;
            addr_hi_q   <= 8'h00;
            addr_lo_q   <= 8'h00;
            data_sh_q   <= 8'h00;
            i2c_sdat_oe <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 16'h0000;
            wr_data     <= 8'h00;
            err         <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            ack_on_q    <= ack_on_n;
            ack_slot_q  <= ack_slot_n;
            ign_err_q   <= ign_err_n;
            addr_hi_q   <= addr_hi_n;
            addr_lo_q   <= addr_lo_n;
            data_sh_q   <= data_sh_n;
            i2c_sdat_oe <= oe_n;
            wr_valid    <= wr_valid_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            err         <= err_n;
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule
